// File: rtl/cv32e41s_pending_req_sel_if.sv
// cv32e41s_pending_req_sel_if: request/mask/flush inputs, offer handshake and status outputs
interface cv32e41s_pending_req_sel_if #(parameter int LEN = 32);
  localparam int IDXW = $clog2(LEN);
  logic [LEN-1:0]  req_set_i;
  logic [LEN-1:0]  mask_i;
  logic            flush_i;
  logic            valid_o;
  logic [IDXW-1:0] idx_o;
  logic            ready_i;
  logic [LEN-1:0]  pending_o;
  logic            overflow_o;
  modport master (output req_set_i, mask_i, flush_i, ready_i, input valid_o, idx_o, pending_o, overflow_o);
  modport slave (input req_set_i, mask_i, flush_i, ready_i, output valid_o, idx_o, pending_o, overflow_o);
endinterface

// File: rtl/cv32e41s_pending_req_sel.sv
// cv32e41s_pending_req_sel: sticky pending lines, lowest-index select, valid/ready offer (clk, rst, bus: req_set/mask/flush/ready in, valid/idx/pending/overflow out)
module cv32e41s_pending_req_sel #(
  parameter int LEN  = 32,
  parameter int IDXW = $clog2(LEN)
) (
  input logic clk,
  input logic rst,
  cv32e41s_pending_req_sel_if.slave bus
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [LEN-1:0] pending_q, acc_clr, nxt;
  logic [IDXW-1:0] idx_q, idx_d, first;
  logic ovf_q, acc;
  assign acc     = (state_q == OFFER) && bus.ready_i;
  assign acc_clr = acc ? {{(LEN-1){1'b0}}, 1'b1} << idx_q : '0;
  // In IDLE acc_clr is zero, so one encoder on nxt serves both states.
  assign nxt     = pending_q & bus.mask_i & ~acc_clr;
  always_comb begin
    first = '0;
    for (int i = LEN - 1; i >= 0; i--) if (nxt[i]) first = IDXW'(i);
  end
  always_comb begin
    state_d = (state_q == OFFER && !bus.ready_i) || |nxt ? OFFER : IDLE;
    idx_d   = (state_q == IDLE || bus.ready_i) && |nxt ? first : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (bus.flush_i) begin
      pending_q <= '0;
      state_q   <= IDLE;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~acc_clr) | bus.req_set_i;
      state_q   <= state_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_q | |(bus.req_set_i & pending_q & ~acc_clr);
    end
  end
  assign bus.valid_o    = state_q == OFFER;
  assign bus.idx_o      = idx_q;
  assign bus.pending_o  = pending_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_cv32e41s_pending_req_sel.sv
// tb_cv32e41s_pending_req_sel: directed stimulus with scoreboard of accepted indices
module tb_cv32e41s_pending_req_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  cv32e41s_pending_req_sel_if #(.LEN(32)) bus ();
  cv32e41s_pending_req_sel_if #(.LEN(5)) bus5 ();
  cv32e41s_pending_req_sel #(.LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  cv32e41s_pending_req_sel #(.LEN(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i && !bus.flush_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL accept: got idx %0d want none", bus.idx_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.idx_o) != e) begin
          bad++;
          $display("FAIL accept: got idx %0d want %0d", bus.idx_o, e);
        end
      end
    end
  end
  initial begin
    bus.req_set_i = '0; bus.mask_i = '1; bus.flush_i = 0; bus.ready_i = 0;
    bus5.req_set_i = '0; bus5.mask_i = '1; bus5.flush_i = 0; bus5.ready_i = 0;
    tick(); tick(); rst = 0;
    chk("rst_pending", 64'(bus.pending_o), 0);
    chk("rst_valid", 64'(bus.valid_o), 0);
    chk("rst_idx", 64'(bus.idx_o), 0);
    chk("rst_ovf", 64'(bus.overflow_o), 0);
    bus.req_set_i = 32'h14; tick(); bus.req_set_i = '0;
    chk("lat_pending", 64'(bus.pending_o), 64'h14);
    chk("lat_valid_n1", 64'(bus.valid_o), 0);
    tick();
    chk("lat_valid_n2", 64'(bus.valid_o), 1);
    chk("lat_idx", 64'(bus.idx_o), 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_idx", 64'({bus.valid_o, bus.idx_o}), 64'h22);
    end
    exp_q.push_back(2); exp_q.push_back(4);
    bus.ready_i = 1; tick();
    chk("b2b_valid", 64'(bus.valid_o), 1);
    chk("b2b_idx", 64'(bus.idx_o), 4);
    tick(); bus.ready_i = 0;
    chk("drain_valid", 64'(bus.valid_o), 0);
    chk("drain_pending", 64'(bus.pending_o), 0);
    bus.req_set_i = 32'h10; tick(); bus.req_set_i = '0; tick();
    chk("frz_start", 64'(bus.idx_o), 4);
    bus.req_set_i = 32'h02; bus.mask_i = ~32'h10; tick(); bus.req_set_i = '0;
    chk("frz_idx", 64'({bus.valid_o, bus.idx_o}), 64'h24);
    tick();
    chk("frz_idx2", 64'(bus.idx_o), 4);
    exp_q.push_back(4); exp_q.push_back(1);
    bus.ready_i = 1; tick();
    chk("frz_next", 64'(bus.idx_o), 1);
    tick(); bus.ready_i = 0; bus.mask_i = '1;
    chk("frz_valid", 64'(bus.valid_o), 0);
    chk("frz_pending", 64'(bus.pending_o), 0);
    bus.req_set_i = 32'h18; tick(); bus.req_set_i = '0; tick();
    chk("re_idx3", 64'(bus.idx_o), 3);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(3);
    bus.ready_i = 1; bus.req_set_i = 32'h08; tick(); bus.req_set_i = '0;
    chk("re_pending", 64'(bus.pending_o), 64'h18);
    chk("re_ovf", 64'(bus.overflow_o), 0);
    chk("re_idx4", 64'(bus.idx_o), 4);
    tick();
    chk("re_idx3b", 64'({bus.valid_o, bus.idx_o}), 64'h23);
    tick(); bus.ready_i = 0;
    chk("re_done", 64'(bus.valid_o), 0);
    bus.req_set_i = 32'h80; tick(); tick(); bus.req_set_i = '0;
    chk("ovf_set", 64'(bus.overflow_o), 1);
    tick();
    chk("ovf_hold", 64'(bus.overflow_o), 1);
    bus.flush_i = 1; bus.req_set_i = 32'hFF; tick(); bus.flush_i = 0; bus.req_set_i = '0;
    chk("fl_pending", 64'(bus.pending_o), 0);
    chk("fl_ovf", 64'(bus.overflow_o), 0);
    chk("fl_valid", 64'(bus.valid_o), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);
    tick(); tick();
    chk("l5_none", 64'(bus5.valid_o), 0);
    bus5.req_set_i = 5'h10; tick(); bus5.req_set_i = '0; tick();
    chk("l5_idx", 64'({bus5.valid_o, bus5.idx_o}), 64'h0C);
    rst = 1; tick(); rst = 0;
    chk("l5_rst", 64'({bus5.valid_o, bus5.idx_o, bus5.pending_o, bus5.overflow_o}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
